// File: rtl/counter_step_decoder_pkg.sv
// Shared types and default sizes for the counter step decoder.
package counter_step_pkg;

  localparam int DEF_WIDTH  = 4;
  localparam int DEF_LCNT_W = 8;

  typedef enum logic [0:0] {
    INIT,
    TRACK
  } state_e;

  typedef enum logic [2:0] {
    EV_NONE,
    EV_HOLD,
    EV_UP,
    EV_DN,
    EV_LOAD
  } ev_e;

endpackage

// File: rtl/counter_step_decoder_if.sv
// Observation bus of the step decoder: sampled count in, decoded events out.
// run_len exists only when COUNTER_STEP_DECODER_RUNLEN_EN is defined.
interface counter_step_decoder_if #(
  parameter int WIDTH  = counter_step_pkg::DEF_WIDTH,
  parameter int LCNT_W = counter_step_pkg::DEF_LCNT_W
) ();
  logic              sample_en;
  logic [WIDTH-1:0]  count_in;
  logic              dir_up;
  logic              step_up;
  logic              step_dn;
  logic              hold;
  logic              load_det;
  logic              wrap;
  logic              dir_chg;
  logic [LCNT_W-1:0] load_cnt;
  logic              primed;
`ifdef COUNTER_STEP_DECODER_RUNLEN_EN
  logic [15:0]       run_len;
`endif

  modport master (
    output sample_en, count_in,
    input  dir_up, step_up, step_dn, hold, load_det, wrap, dir_chg, load_cnt, primed
`ifdef COUNTER_STEP_DECODER_RUNLEN_EN
    , input run_len
`endif
  );

  modport slave (
    input  sample_en, count_in,
    output dir_up, step_up, step_dn, hold, load_det, wrap, dir_chg, load_cnt, primed
`ifdef COUNTER_STEP_DECODER_RUNLEN_EN
    , output run_len
`endif
  );
endinterface

// File: rtl/counter_step_decoder_step_classifier.sv
// Combinational decode of one sample against the previous one: modular diff
// mapped to hold / +1 / -1 / jump, with wrap across max<->0.
module step_classifier
  import counter_step_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             valid_i,
  input  logic [WIDTH-1:0] prev_i,
  input  logic [WIDTH-1:0] cur_i,
  output ev_e              ev_o,
  output logic             wrap_o
);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
  localparam logic [WIDTH-1:0] MAX = '1;

  logic [WIDTH-1:0] diff;
  assign diff = cur_i - prev_i;

  // +1 is tested before -1 so a 1-bit counter resolves toggles as step up
  always_comb begin
    ev_o   = EV_NONE;
    wrap_o = 1'b0;
    if (valid_i) begin
      if (diff == '0) begin
        ev_o = EV_HOLD;
      end else if (diff == ONE) begin
        ev_o   = EV_UP;
        wrap_o = (prev_i == MAX);
      end else if (diff == MAX) begin
        ev_o   = EV_DN;
        wrap_o = (prev_i == '0);
      end else begin
        ev_o = EV_LOAD;
      end
    end
  end
endmodule

// File: rtl/counter_step_decoder.sv
// Recovers up/down/load activity of a counter from its output stream.
// Optional run-length output: define COUNTER_STEP_DECODER_RUNLEN_EN.
module counter_step_decoder
  import counter_step_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int LCNT_W = DEF_LCNT_W
) (
  input logic                    clk,
  input logic                    reset,
  counter_step_decoder_if.slave  bus
);
  state_e            state_q, state_d;
  logic [WIDTH-1:0]  prev_q, prev_d;
  logic              dir_up_q, dir_up_d;
  logic              step_up_q, step_up_d, step_dn_q, step_dn_d;
  logic              hold_q, hold_d, load_det_q, load_det_d;
  logic              wrap_q, wrap_d, dir_chg_q, dir_chg_d;
  logic [LCNT_W-1:0] load_cnt_q, load_cnt_d;
  logic              primed_q, primed_d;
  ev_e               ev;
  logic              ev_wrap;

  function automatic logic [LCNT_W-1:0] sat_inc_lcnt(input logic [LCNT_W-1:0] v);
    return (v == '1) ? v : v + LCNT_W'(1);
  endfunction

  step_classifier #(.WIDTH(WIDTH)) u_cls (
    .valid_i (bus.sample_en && (state_q == TRACK)),
    .prev_i  (prev_q),
    .cur_i   (bus.count_in),
    .ev_o    (ev),
    .wrap_o  (ev_wrap)
  );

  always_comb begin
    state_d    = state_q;
    prev_d     = prev_q;
    dir_up_d   = dir_up_q;
    load_cnt_d = load_cnt_q;
    primed_d   = primed_q;
    step_up_d  = 1'b0;
    step_dn_d  = 1'b0;
    hold_d     = 1'b0;
    load_det_d = 1'b0;
    wrap_d     = 1'b0;
    dir_chg_d  = 1'b0;
    if (bus.sample_en) begin
      prev_d = bus.count_in;
      if (state_q == INIT) begin
        primed_d = 1'b1;
        state_d  = TRACK;
      end else begin
        step_up_d  = (ev == EV_UP);
        step_dn_d  = (ev == EV_DN);
        hold_d     = (ev == EV_HOLD);
        load_det_d = (ev == EV_LOAD);
        wrap_d     = ev_wrap;
        dir_chg_d  = (step_up_d && !dir_up_q) || (step_dn_d && dir_up_q);
        if (step_up_d) dir_up_d = 1'b1;
        if (step_dn_d) dir_up_d = 1'b0;
        if (load_det_d) load_cnt_d = sat_inc_lcnt(load_cnt_q);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= INIT;
      prev_q     <= '0;
      dir_up_q   <= 1'b1;
      step_up_q  <= 1'b0;
      step_dn_q  <= 1'b0;
      hold_q     <= 1'b0;
      load_det_q <= 1'b0;
      wrap_q     <= 1'b0;
      dir_chg_q  <= 1'b0;
      load_cnt_q <= '0;
      primed_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      prev_q     <= prev_d;
      dir_up_q   <= dir_up_d;
      step_up_q  <= step_up_d;
      step_dn_q  <= step_dn_d;
      hold_q     <= hold_d;
      load_det_q <= load_det_d;
      wrap_q     <= wrap_d;
      dir_chg_q  <= dir_chg_d;
      load_cnt_q <= load_cnt_d;
      primed_q   <= primed_d;
    end
  end

  assign bus.dir_up   = dir_up_q;
  assign bus.step_up  = step_up_q;
  assign bus.step_dn  = step_dn_q;
  assign bus.hold     = hold_q;
  assign bus.load_det = load_det_q;
  assign bus.wrap     = wrap_q;
  assign bus.dir_chg  = dir_chg_q;
  assign bus.load_cnt = load_cnt_q;
  assign bus.primed   = primed_q;

`ifdef COUNTER_STEP_DECODER_RUNLEN_EN
  logic [15:0] run_len_q, run_len_d;
  logic        after_load_q, after_load_d;

  function automatic logic [15:0] sat_inc_rl(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // A run restarts on a reversal or on the first step following a jump
  always_comb begin
    run_len_d    = run_len_q;
    after_load_d = after_load_q;
    if (load_det_d) begin
      after_load_d = 1'b1;
    end else if (step_up_d || step_dn_d) begin
      after_load_d = 1'b0;
      run_len_d    = (dir_chg_d || after_load_q) ? 16'd1 : sat_inc_rl(run_len_q);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      run_len_q    <= '0;
      after_load_q <= 1'b0;
    end else begin
      run_len_q    <= run_len_d;
      after_load_q <= after_load_d;
    end
  end

  assign bus.run_len = run_len_q;
`endif
endmodule

// File: tb/tb_counter_step_decoder.sv
// Directed bench for counter_step_decoder (WIDTH=4, LCNT_W=8, plus LCNT_W=2 copy).
module tb_counter_step_decoder;
  logic clk = 1'b0;
  logic reset;
  int   n_chk  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  counter_step_decoder_if #(.WIDTH(4), .LCNT_W(8)) bus ();
  counter_step_decoder_if #(.WIDTH(4), .LCNT_W(2)) bus2 ();

  counter_step_decoder #(.WIDTH(4), .LCNT_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  counter_step_decoder #(.WIDTH(4), .LCNT_W(2)) dut_sat (
    .clk   (clk),
    .reset (reset),
    .bus   (bus2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic samp(input logic en, input logic [3:0] v);
    @(negedge clk);
    bus.sample_en  = en;
    bus.count_in   = v;
    bus2.sample_en = en;
    bus2.count_in  = v;
    @(posedge clk);
    #1;
  endtask

  // pulse vector order: {step_up, step_dn, hold, load_det, wrap, dir_chg}
  task automatic expect_ev(input string tag, input logic [5:0] pulses, input logic dir,
                           input logic [7:0] lcnt, input logic primed, input logic [15:0] rl);
    check({tag, ".pulses"},
          {26'd0, bus.step_up, bus.step_dn, bus.hold, bus.load_det, bus.wrap, bus.dir_chg},
          {26'd0, pulses});
    check({tag, ".dir_up"}, {31'd0, bus.dir_up}, {31'd0, dir});
    check({tag, ".load_cnt"}, {24'd0, bus.load_cnt}, {24'd0, lcnt});
    check({tag, ".primed"}, {31'd0, bus.primed}, {31'd0, primed});
`ifdef COUNTER_STEP_DECODER_RUNLEN_EN
    check({tag, ".run_len"}, {16'd0, bus.run_len}, {16'd0, rl});
`else
    if (rl > 16'hFFFF) $display("unreachable");
`endif
  endtask

  localparam logic [5:0] P_NONE = 6'b000000;
  localparam logic [5:0] P_HOLD = 6'b001000;
  localparam logic [5:0] P_UP   = 6'b100000;
  localparam logic [5:0] P_UPW  = 6'b100010;
  localparam logic [5:0] P_UPC  = 6'b100001;
  localparam logic [5:0] P_DN   = 6'b010000;
  localparam logic [5:0] P_DNC  = 6'b010001;
  localparam logic [5:0] P_DNW  = 6'b010010;
  localparam logic [5:0] P_LOAD = 6'b000100;

  initial begin
    reset          = 1'b1;
    bus.sample_en  = 1'b0;
    bus.count_in   = 4'd0;
    bus2.sample_en = 1'b0;
    bus2.count_in  = 4'd0;
    samp(1'b1, 4'd5);
    samp(1'b1, 4'd6);
    expect_ev("reset", P_NONE, 1'b1, 8'd0, 1'b0, 16'd0);
    reset = 1'b0;

    samp(1'b1, 4'd12); expect_ev("prime12", P_NONE, 1'b1, 8'd0, 1'b1, 16'd0);
    samp(1'b1, 4'd12); expect_ev("hold12",  P_HOLD, 1'b1, 8'd0, 1'b1, 16'd0);
    samp(1'b1, 4'd13); expect_ev("up13",    P_UP,   1'b1, 8'd0, 1'b1, 16'd1);
    samp(1'b1, 4'd14); expect_ev("up14",    P_UP,   1'b1, 8'd0, 1'b1, 16'd2);
    samp(1'b1, 4'd15); expect_ev("up15",    P_UP,   1'b1, 8'd0, 1'b1, 16'd3);
    samp(1'b1, 4'd0);  expect_ev("up0wrap", P_UPW,  1'b1, 8'd0, 1'b1, 16'd4);
    samp(1'b1, 4'd1);  expect_ev("up1",     P_UP,   1'b1, 8'd0, 1'b1, 16'd5);
    samp(1'b1, 4'd2);  expect_ev("up2",     P_UP,   1'b1, 8'd0, 1'b1, 16'd6);

    samp(1'b1, 4'd1);  expect_ev("dn1chg",  P_DNC,  1'b0, 8'd0, 1'b1, 16'd1);
    samp(1'b1, 4'd0);  expect_ev("dn0",     P_DN,   1'b0, 8'd0, 1'b1, 16'd2);
    samp(1'b1, 4'd15); expect_ev("dn15wrap", P_DNW, 1'b0, 8'd0, 1'b1, 16'd3);

    samp(1'b1, 4'd5);  expect_ev("load5",   P_LOAD, 1'b0, 8'd1, 1'b1, 16'd3);
    samp(1'b1, 4'd12); expect_ev("load12",  P_LOAD, 1'b0, 8'd2, 1'b1, 16'd3);
    samp(1'b1, 4'd0);  expect_ev("load0",   P_LOAD, 1'b0, 8'd3, 1'b1, 16'd3);
    check("sat.pre", {30'd0, bus2.load_cnt}, 32'd3);
    samp(1'b1, 4'd7);  expect_ev("load7",   P_LOAD, 1'b0, 8'd4, 1'b1, 16'd3);
    check("sat.hold", {30'd0, bus2.load_cnt}, 32'd3);

    samp(1'b1, 4'd3);  expect_ev("load3",   P_LOAD, 1'b0, 8'd5, 1'b1, 16'd3);
    samp(1'b0, 4'd9);  expect_ev("ign9a",   P_NONE, 1'b0, 8'd5, 1'b1, 16'd3);
    samp(1'b0, 4'd9);  expect_ev("ign9b",   P_NONE, 1'b0, 8'd5, 1'b1, 16'd3);
    samp(1'b1, 4'd4);  expect_ev("up4chg",  P_UPC,  1'b1, 8'd5, 1'b1, 16'd1);
    check("sat.after", {30'd0, bus2.load_cnt}, 32'd3);

    samp(1'b1, 4'd7);  expect_ev("load7b",  P_LOAD, 1'b1, 8'd6, 1'b1, 16'd1);
    reset = 1'b1;
    samp(1'b1, 4'd8);  expect_ev("midrst",  P_NONE, 1'b1, 8'd0, 1'b0, 16'd0);
    reset = 1'b0;
    samp(1'b1, 4'd8);  expect_ev("reprime", P_NONE, 1'b1, 8'd0, 1'b1, 16'd0);
    samp(1'b1, 4'd7);  expect_ev("dn7chg",  P_DNC,  1'b0, 8'd0, 1'b1, 16'd1);
    samp(1'b1, 4'd7);  expect_ev("hold7",   P_HOLD, 1'b0, 8'd0, 1'b1, 16'd1);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule
